// File: rtl/drv_pkg.sv
// ---------------------------------------------------------------------------
// drv_pkg
// Shared types and helpers for the current-steering DAC driver slice.
//   drv_state_t    : power sequencing states of the driver FSM
//   BIN_W_DEF      : default width of the binary (LSB) segment
//   THERM_W_DEF    : default width of the thermometric (MSB) segment
//   THERM_W_MAX    : widest thermometer word is_thermometer() can judge
//   is_thermometer : 1 when a word is contiguous ones from the LSB
//                    (0, 1, 3, 7, ... all-ones)
// ---------------------------------------------------------------------------
package drv_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    WAKE   = 2'd1,
    ACTIVE = 2'd2,
    PARK   = 2'd3
  } drv_state_t;

  localparam int BIN_W_DEF   = 7;
  localparam int THERM_W_DEF = 17;
  localparam int THERM_W_MAX = 64;

  // A thermometer word w has the form 2^n - 1, so w + 1 is a power of two
  // and shares no set bit with w. Callers zero-extend narrower words, which
  // keeps the all-ones case valid because the carry lands above the word.
  function automatic bit is_thermometer(input logic [THERM_W_MAX-1:0] word);
    logic [THERM_W_MAX-1:0] plus_one;
    plus_one = word + THERM_W_MAX'(1);
    return ((word & plus_one) == '0);
  endfunction

endpackage

// File: rtl/drv_sync.sv
// ---------------------------------------------------------------------------
// drv_sync
// Single-bit multi-flop synchroniser, cleared to 0 by reset so a slow or
// absent power-good input reads as "not ready" straight out of reset.
//   clk        : destination clock
//   rst        : asynchronous, active-high reset (chain cleared to 0)
//   async_bit  : level from another clock domain or an analog monitor
//   sync_bit   : the same level, SYNC_STAGES clk edges later
// ---------------------------------------------------------------------------
module drv_sync
  import drv_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_bit,
  output logic sync_bit
);

  logic [SYNC_STAGES-1:0] chain;

  // Plain shift chain; the first flop may go metastable, the rest give it
  // SYNC_STAGES-1 clock periods to resolve before anyone looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_bit};
    end
  end

  assign sync_bit = chain[SYNC_STAGES-1];

endmodule

// File: rtl/dac_driver_resync.sv
// ---------------------------------------------------------------------------
// dac_driver_resync
// Resynchronises the binary and thermometric switch-control words of a
// current-steering DAC to the converter clock, builds the complementary
// rails and sequences power-up / power-down.
//
// Ports
//   clk           : converter clock
//   rst           : asynchronous, active-high reset
//   pdb           : power-down negate, asynchronous
//   vdd_ok        : supply-good flag from the analog monitor, asynchronous
//   datain        : binary control word        [BIN_W]
//   datatherm     : thermometric control word  [THERM_W]
//   databinout    : resynchronised binary drive
//   databinoutb   : complement binary drive
//   datathermout  : resynchronised thermometric drive
//   datathermoutb : complement thermometric drive
//   drv_ready     : high while the FSM is in ACTIVE
//   therm_err     : one-cycle flag on an output word that replaced an
//                   invalid thermometer input
//
// Build option
//   DRV_THERM_CHECK_EN : when defined, invalid thermometer words are replaced
//                        by the last valid one and flagged on therm_err.
//                        Otherwise datatherm passes unchecked, therm_err = 0.
//
// Rail encoding: "off" is both rails 0 (every switch open); "code zero" is
// true rails 0 and complement rails all 1.
// ---------------------------------------------------------------------------
module dac_driver_resync
  import drv_pkg::*;
#(
  parameter int BIN_W       = BIN_W_DEF,
  parameter int THERM_W     = THERM_W_DEF,
  parameter int PIPE_DEPTH  = 2,
  parameter int WAKE_CYCLES = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pdb,
  input  logic               vdd_ok,
  input  logic [BIN_W-1:0]   datain,
  input  logic [THERM_W-1:0] datatherm,
  output logic [BIN_W-1:0]   databinout,
  output logic [BIN_W-1:0]   databinoutb,
  output logic [THERM_W-1:0] datathermout,
  output logic [THERM_W-1:0] datathermoutb,
  output logic               drv_ready,
  output logic               therm_err
);

  localparam int CNT_W = 8;

  logic              pdb_s;
  logic              vdd_ok_s;
  logic              en_s;

  drv_state_t        state;
  drv_state_t        next_state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;

  logic              pass_data;
  logic              flush;
  logic [BIN_W-1:0]  stage0_bin;
  logic [THERM_W-1:0] stage0_therm;

  logic [BIN_W-1:0]   pipe_bin    [PIPE_DEPTH];
  logic [BIN_W-1:0]   pipe_binb   [PIPE_DEPTH];
  logic [THERM_W-1:0] pipe_therm  [PIPE_DEPTH];
  logic [THERM_W-1:0] pipe_thermb [PIPE_DEPTH];

`ifdef DRV_THERM_CHECK_EN
  logic               stage0_err;
  logic [THERM_W-1:0] last_valid;
  logic [THERM_W-1:0] last_valid_next;
  logic               pipe_err [PIPE_DEPTH];
`endif

  // Both enables cross into the clk domain separately; the driver only
  // runs while the supply is good and power-down is negated.
  drv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pdb (
    .clk       (clk),
    .rst       (rst),
    .async_bit (pdb),
    .sync_bit  (pdb_s)
  );

  drv_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_vdd_ok (
    .clk       (clk),
    .rst       (rst),
    .async_bit (vdd_ok),
    .sync_bit  (vdd_ok_s)
  );

  assign en_s = pdb_s & vdd_ok_s;

  // State and shared counter registers. The counter times the wake hold in
  // WAKE and the drain period in PARK; it is idle (0) elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Power sequencing. Losing enable in WAKE abandons the wake-up outright,
  // while losing it in ACTIVE parks the switches at code zero first. PARK
  // ignores enable so a glitchy pdb cannot skip the drain.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      OFF: begin
        if (en_s) begin
          next_state = WAKE;
          cnt_next   = CNT_W'(WAKE_CYCLES - 1);
        end
      end
      WAKE: begin
        if (!en_s) begin
          next_state = OFF;
          cnt_next   = '0;
        end else if (cnt == '0) begin
          next_state = ACTIVE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (!en_s) begin
          next_state = PARK;
          cnt_next   = CNT_W'(PIPE_DEPTH - 1);
        end
      end
      PARK: begin
        if (cnt == '0) begin
          next_state = OFF;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        next_state = OFF;
        cnt_next   = '0;
      end
    endcase
  end

  // Stage-0 word selection. Live data only enters while the driver stays in
  // ACTIVE; every other case feeds code zero (true rail 0), so X/Z on the
  // data pins never reaches the switches outside ACTIVE.
  always_comb begin
    pass_data    = (state == ACTIVE) && (next_state == ACTIVE);
    flush        = ((state == OFF) && (next_state == WAKE)) ||
                   ((state == ACTIVE) && (next_state == PARK));
    stage0_bin   = '0;
    stage0_therm = '0;
`ifdef DRV_THERM_CHECK_EN
    stage0_err      = 1'b0;
    last_valid_next = '0;
    if (pass_data) begin
      stage0_bin      = datain;
      last_valid_next = last_valid;
      if (is_thermometer(THERM_W_MAX'(datatherm))) begin
        stage0_therm    = datatherm;
        last_valid_next = datatherm;
      end else begin
        stage0_therm = last_valid;
        stage0_err   = 1'b1;
      end
    end
`else
    if (pass_data) begin
      stage0_bin   = datain;
      stage0_therm = datatherm;
    end
`endif
  end

`ifdef DRV_THERM_CHECK_EN
  // Substitute word for bad thermometer inputs. It falls back to 0 whenever
  // the driver leaves ACTIVE, so a fresh wake-up never replays stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid <= '0;
    end else begin
      last_valid <= last_valid_next;
    end
  end
`endif

  // Resync pipeline. True and complement rails are separate flops fed from
  // the same stage-0 word, so both rails change on the same edge. Entering
  // WAKE or PARK loads every stage with code zero at once: the switches sit
  // at code zero for the whole wake hold, and in-flight words are dropped as
  // soon as drv_ready falls. Heading to OFF opens every switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_bin[i]    <= '0;
        pipe_binb[i]   <= '0;
        pipe_therm[i]  <= '0;
        pipe_thermb[i] <= '0;
`ifdef DRV_THERM_CHECK_EN
        pipe_err[i]    <= 1'b0;
`endif
      end
    end else if (next_state == OFF) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_bin[i]    <= '0;
        pipe_binb[i]   <= '0;
        pipe_therm[i]  <= '0;
        pipe_thermb[i] <= '0;
`ifdef DRV_THERM_CHECK_EN
        pipe_err[i]    <= 1'b0;
`endif
      end
    end else if (flush) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        pipe_bin[i]    <= '0;
        pipe_binb[i]   <= '1;
        pipe_therm[i]  <= '0;
        pipe_thermb[i] <= '1;
`ifdef DRV_THERM_CHECK_EN
        pipe_err[i]    <= 1'b0;
`endif
      end
    end else begin
      pipe_bin[0]    <= stage0_bin;
      pipe_binb[0]   <= ~stage0_bin;
      pipe_therm[0]  <= stage0_therm;
      pipe_thermb[0] <= ~stage0_therm;
`ifdef DRV_THERM_CHECK_EN
      pipe_err[0]    <= stage0_err;
`endif
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        pipe_bin[i]    <= pipe_bin[i-1];
        pipe_binb[i]   <= pipe_binb[i-1];
        pipe_therm[i]  <= pipe_therm[i-1];
        pipe_thermb[i] <= pipe_thermb[i-1];
`ifdef DRV_THERM_CHECK_EN
        pipe_err[i]    <= pipe_err[i-1];
`endif
      end
    end
  end

  assign databinout    = pipe_bin[PIPE_DEPTH-1];
  assign databinoutb   = pipe_binb[PIPE_DEPTH-1];
  assign datathermout  = pipe_therm[PIPE_DEPTH-1];
  assign datathermoutb = pipe_thermb[PIPE_DEPTH-1];
  assign drv_ready     = (state == ACTIVE);

`ifdef DRV_THERM_CHECK_EN
  assign therm_err = pipe_err[PIPE_DEPTH-1];
`else
  assign therm_err = 1'b0;
`endif

endmodule
